// File: rtl/lh_pkg.sv
// rtl/lh_pkg.sv - shared types and constants for the light_hash arbiter
package lh_pkg;

   typedef enum logic [1:0] {IDLE, SEND, WAIT_BUSY, WAIT_DIG} lh_arb_state_t;

   localparam logic [7:0] NUL_CHAR = 8'h00;
   localparam int         DIGEST_W = 64;

endpackage

// File: rtl/lh_rr_arbiter.sv
// rtl/lh_rr_arbiter.sv - combinational round-robin picker starting at a pointer
module lh_rr_arbiter
   import lh_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         req,
   input  logic [$clog2(NUM_REQ)-1:0] ptr,
   output logic [NUM_REQ-1:0]         grant,
   output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

   localparam int IDX_W = $clog2(NUM_REQ);

   logic [IDX_W:0]   sum;
   logic [IDX_W-1:0] cand;
   logic             found;

   // walk the requesters from ptr upward (wrapping) and take the first active one
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      sum       = '0;
      cand      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         sum = {1'b0, ptr} + (IDX_W+1)'(k);
         if (sum >= (IDX_W+1)'(NUM_REQ)) begin
            sum = sum - (IDX_W+1)'(NUM_REQ);
         end
         cand = sum[IDX_W-1:0];
         if (!found && req[cand]) begin
            found       = 1'b1;
            grant[cand] = 1'b1;
            grant_idx   = cand;
         end
      end
   end

endmodule

// File: rtl/light_hash_arbiter.sv
// rtl/light_hash_arbiter.sv - message-granular round-robin sharing of one light_hash core
module light_hash_arbiter
   import lh_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [8*NUM_REQ-1:0]  req_char,
   output logic [NUM_REQ-1:0]    req_ready,
   output logic [NUM_REQ-1:0]    req_err,
   output logic [NUM_REQ-1:0]    dig_valid,
   output logic [NUM_REQ-1:0]    dig_abort,
   output logic [DIGEST_W-1:0]   dig_data,
   output logic [7:0]            lh_ptxt_char,
   output logic                  lh_ptxt_valid,
   input  logic                  lh_busy,
   input  logic [DIGEST_W-1:0]   lh_digest,
   input  logic                  lh_digest_ready,
   input  logic                  lh_err_invalid
);

   localparam int IDX_W = $clog2(NUM_REQ);
   // wait_cnt holds the number of cycles since the NUL byte; abort is registered,
   // so deciding one cycle early makes it visible exactly TIMEOUT_CYC cycles after NUL
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

   lh_arb_state_t       state;
   lh_arb_state_t       state_nxt;
   logic [IDX_W-1:0]    owner;
   logic [IDX_W-1:0]    owner_next;
   logic [IDX_W-1:0]    rr_ptr;
   logic [NUM_REQ-1:0]  owner_onehot;
   logic [7:0]          owner_char;
   logic                owner_valid;
   logic [NUM_REQ-1:0]  grant;
   logic [IDX_W-1:0]    grant_idx;
   logic [15:0]         wait_cnt;
   logic                dig_hit;
   logic                dig_tmo;

   lh_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .req       (req_valid),
      .ptr       (rr_ptr),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   assign owner_onehot = NUM_REQ'(1) << owner;
   assign owner_valid  = req_valid[owner];
   assign owner_next   = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

   // select the owner's byte lane
   always_comb begin
      owner_char = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (owner == IDX_W'(i)) begin
            owner_char = req_char[8*i +: 8];
         end
      end
   end

   // next-state and per-state core/requester strobes
   always_comb begin
      state_nxt     = state;
      lh_ptxt_valid = 1'b0;
      lh_ptxt_char  = '0;
      req_ready     = '0;
      req_err       = '0;
      dig_hit       = 1'b0;
      dig_tmo       = 1'b0;
      case (state)
         IDLE: begin
            if (|grant) begin
               state_nxt = SEND;
            end
         end
         SEND: begin
            lh_ptxt_valid = 1'b1;
            lh_ptxt_char  = owner_char;
            req_ready     = owner_onehot;
            req_err       = lh_err_invalid ? owner_onehot : '0;
            state_nxt     = (owner_char == NUL_CHAR) ? WAIT_DIG : WAIT_BUSY;
         end
         WAIT_BUSY: begin
            // the owner keeps the lock even while it has nothing to send
            if (!lh_busy && owner_valid) begin
               state_nxt = SEND;
            end
         end
         WAIT_DIG: begin
            if (lh_digest_ready) begin
               dig_hit   = 1'b1;
               state_nxt = IDLE;
            end else if (wait_cnt == TMO_LAST) begin
               dig_tmo   = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // owner latch on grant and round-robin advance once a message ends either way
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner  <= '0;
         rr_ptr <= '0;
      end else begin
         if (state == IDLE) begin
            owner <= grant_idx;
         end
         if (dig_hit || dig_tmo) begin
            rr_ptr <= owner_next;
         end
      end
   end

   // cycles since the NUL byte, only advancing while the digest is awaited
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt <= 16'd1;
      end else if (state == WAIT_DIG) begin
         wait_cnt <= wait_cnt + 16'd1;
      end else begin
         wait_cnt <= 16'd1;
      end
   end

   // digest capture and completion pulses to the owner
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dig_data  <= '0;
         dig_valid <= '0;
         dig_abort <= '0;
      end else begin
         dig_valid <= dig_hit ? owner_onehot : '0;
         dig_abort <= dig_tmo ? owner_onehot : '0;
         if (dig_hit) begin
            dig_data <= lh_digest;
         end
      end
   end

endmodule

// File: tb/tb_light_hash_arbiter.sv
// tb/tb_light_hash_arbiter.sv - self-checking bench for light_hash_arbiter
module tb_light_hash_arbiter;
   import lh_pkg::*;

   localparam int N   = 4;
   localparam int TMO = 16;
   localparam int MEM = 64;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req_valid;
   logic [8*N-1:0] req_char;
   logic [N-1:0]   req_ready, req_err, dig_valid, dig_abort;
   logic [63:0]    dig_data;
   logic [7:0]     lh_ptxt_char;
   logic           lh_ptxt_valid, lh_busy, lh_digest_ready, lh_err_invalid;
   logic [63:0]    lh_digest;

   always #5 clk = ~clk;

   light_hash_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(TMO)) dut (
      .clk             (clk),
      .rst             (rst),
      .req_valid       (req_valid),
      .req_char        (req_char),
      .req_ready       (req_ready),
      .req_err         (req_err),
      .dig_valid       (dig_valid),
      .dig_abort       (dig_abort),
      .dig_data        (dig_data),
      .lh_ptxt_char    (lh_ptxt_char),
      .lh_ptxt_valid   (lh_ptxt_valid),
      .lh_busy         (lh_busy),
      .lh_digest       (lh_digest),
      .lh_digest_ready (lh_digest_ready),
      .lh_err_invalid  (lh_err_invalid)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // stand-in core: digest = running concatenation of accepted bytes, '#' is invalid
   logic [63:0] core_h, core_pend;
   int          core_busy_n, core_dig_n;
   bit          core_mute, core_inj;

   assign lh_busy        = (core_busy_n != 0);
   assign lh_err_invalid = lh_ptxt_valid && (lh_ptxt_char == 8'h23);

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         core_h <= '0; core_pend <= '0; core_busy_n <= 0; core_dig_n <= 0;
         lh_digest_ready <= 1'b0; lh_digest <= '0;
      end else begin
         lh_digest_ready <= 1'b0;
         if (core_busy_n != 0) core_busy_n <= core_busy_n - 1;
         if (core_dig_n != 0) core_dig_n <= core_dig_n - 1;
         if (core_dig_n == 1) begin
            lh_digest_ready <= 1'b1;
            lh_digest       <= core_pend;
         end
         if (core_inj) begin
            lh_digest_ready <= 1'b1;
            lh_digest       <= 64'hdead_beef;
         end
         if (lh_ptxt_valid) begin
            if (lh_ptxt_char == 8'h00) begin
               core_pend <= core_h;
               core_h    <= '0;
               if (!core_mute) core_dig_n <= 3;
            end else begin
               core_busy_n <= 2;
               if (lh_ptxt_char != 8'h23) core_h <= {core_h[55:0], lh_ptxt_char};
            end
         end
      end
   end

   // message sources
   logic [7:0] src_mem [N][MEM];
   int         src_wr [N];
   int         src_rd [N];
   bit         stall [N];
   bit         pop_pend [N];

   initial begin : driver
      req_valid = '0;
      req_char  = '0;
      forever begin
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++) begin
            if (pop_pend[i]) begin
               src_rd[i]++;
               pop_pend[i] = 1'b0;
            end
            req_valid[i] = (src_rd[i] < src_wr[i]) && !stall[i];
            req_char[8*i +: 8] = (src_rd[i] < src_wr[i]) ? src_mem[i][src_rd[i]] : 8'h00;
         end
      end
   end

   // transaction-level reference: lock ownership, byte order, digests, timeouts
   int           cyc, lock, rr_m, last_send, exp_g;
   logic [N-1:0] prev_valid;
   logic [63:0]  last_dig;
   logic [63:0]  acc [N];
   logic [63:0]  rdig [N];
   int           chk_rd [N];
   bit           awaiting [N];
   int           nul_cyc [N];
   int           ready_cnt [N], err_cnt [N], done_cnt [N], abort_cnt [N];
   int           first_cyc [N], done_cyc [N], abort_cyc [N];

   function automatic int rr_pick(input logic [N-1:0] v, input int p);
      for (int k = 0; k < N; k++) begin
         if (v[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   task automatic release_lock(input int i);
      awaiting[i] = 1'b0;
      acc[i]      = '0;
      lock        = -1;
      rr_m        = (i + 1) % N;
   endtask

   initial begin : compare
      logic [7:0] eb;
      cyc = 0; lock = -1; rr_m = 0; last_send = -100; last_dig = '0; prev_valid = '0;
      for (int i = 0; i < N; i++) begin
         acc[i] = '0; rdig[i] = '0; chk_rd[i] = 0; awaiting[i] = 1'b0; nul_cyc[i] = 0;
         ready_cnt[i] = 0; err_cnt[i] = 0; done_cnt[i] = 0; abort_cnt[i] = 0;
         first_cyc[i] = 0; done_cyc[i] = 0; abort_cyc[i] = 0;
      end
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            lock = -1; rr_m = 0; last_send = -100; last_dig = '0;
            for (int i = 0; i < N; i++) begin
               chk_rd[i] = 0; acc[i] = '0; awaiting[i] = 1'b0;
            end
         end else begin
            check("pulse_onehot", ($countones(req_ready) <= 1) && ($countones(req_err) <= 1) &&
                  ($countones(dig_valid) <= 1) && ($countones(dig_abort) <= 1), 1);
            check("ptxt_valid_vs_ready", lh_ptxt_valid, |req_ready);
            for (int i = 0; i < N; i++) begin
               if (req_ready[i]) begin
                  if (lock == -1) begin
                     exp_g = rr_pick(prev_valid, rr_m);
                     check("grant_order", i, exp_g);
                     lock = i;
                     first_cyc[i] = cyc;
                  end else begin
                     check("lock_owner", i, lock);
                  end
                  check("byte_spacing", (cyc - last_send) >= 2, 1);
                  last_send = cyc;
                  if (chk_rd[i] >= src_wr[i]) begin
                     check("ready_without_byte", 0, 1);
                  end else begin
                     eb = src_mem[i][chk_rd[i]];
                     check("ptxt_char", lh_ptxt_char, eb);
                     check("req_err", req_err[i], eb == 8'h23);
                     if (eb == 8'h00) begin
                        awaiting[i] = 1'b1;
                        nul_cyc[i]  = cyc;
                     end else if (eb != 8'h23) begin
                        acc[i] = {acc[i][55:0], eb};
                     end
                     chk_rd[i]++;
                     pop_pend[i] = 1'b1;
                  end
                  ready_cnt[i]++;
                  err_cnt[i] += int'(req_err[i]);
               end
               if (dig_valid[i]) begin
                  check("dig_valid_expected", awaiting[i] && (lock == i), 1);
                  check("dig_data", dig_data, acc[i]);
                  last_dig    = acc[i];
                  rdig[i]     = dig_data;
                  done_cyc[i] = cyc;
                  done_cnt[i]++;
                  release_lock(i);
               end
               if (dig_abort[i]) begin
                  check("abort_expected", awaiting[i] && (lock == i) && core_mute, 1);
                  check("abort_latency", cyc - nul_cyc[i], TMO);
                  check("abort_dig_data", dig_data, last_dig);
                  abort_cyc[i] = cyc;
                  abort_cnt[i]++;
                  release_lock(i);
               end
               if (awaiting[i] && (cyc - nul_cyc[i]) > TMO + 1) begin
                  check("message_completion", 0, 1);
                  release_lock(i);
               end
            end
         end
         prev_valid = req_valid;
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic push_msg(input int r, input string s);
      for (int k = 0; k < s.len(); k++) begin
         src_mem[r][src_wr[r]] = s[k];
         src_wr[r]++;
      end
      src_mem[r][src_wr[r]] = 8'h00;
      src_wr[r]++;
   endtask

   task automatic wait_fin(input int r, input int n, input string nm);
      int b = 0;
      while ((done_cnt[r] + abort_cnt[r]) < n && b < 400) begin
         step();
         b++;
      end
      check(nm, (done_cnt[r] + abort_cnt[r]) >= n, 1);
   endtask

   task automatic wait_rdy(input int r, input int n, input string nm);
      int b = 0;
      while (ready_cnt[r] < n && b < 400) begin
         step();
         b++;
      end
      check(nm, ready_cnt[r] >= n, 1);
   endtask

   task automatic check_quiet(input string nm);
      check({nm, "_strobes"}, {req_ready, req_err, dig_valid, dig_abort, lh_ptxt_valid}, '0);
      check({nm, "_ptxt_char"}, lh_ptxt_char, 8'h00);
      check({nm, "_dig_data"}, dig_data, 64'h0);
   endtask

   initial begin : main
      int b;
      rst = 1'b1; core_mute = 1'b0; core_inj = 1'b0;
      for (int i = 0; i < N; i++) begin
         src_wr[i] = 0; src_rd[i] = 0; stall[i] = 1'b0; pop_pend[i] = 1'b0;
      end
      repeat (3) step();
      check_quiet("reset");
      rst = 1'b0;
      step();

      // contention from rr=0: requester 0 finishes before 2 starts
      push_msg(0, "ab");
      push_msg(2, "ab");
      wait_fin(0, 1, "cont_done0");
      wait_fin(2, 1, "cont_done2");
      check("cont_order", done_cyc[0] < first_cyc[2], 1);
      check("cont_digest", dig_data, 64'h6162);

      // single source "abc" (rr now 3, only 0 requesting)
      push_msg(0, "abc");
      wait_fin(0, 2, "abc_done");
      check("abc_digest", dig_data, 64'h616263);
      check("abc_ready_pulses", ready_cnt[0], 7);

      // tie with rr=1 grants 2 first
      push_msg(0, "ab");
      push_msg(2, "ab");
      wait_fin(0, 3, "tie_done0");
      wait_fin(2, 2, "tie_done2");
      check("tie_order", first_cyc[2] < first_cyc[0], 1);

      // invalid character
      push_msg(1, "a#b");
      wait_fin(1, 1, "inv_done");
      check("inv_err_pulses", err_cnt[1], 1);
      check("inv_digest", dig_data, 64'h6162);

      // timeout: core never answers requester 2, requester 3 queued behind
      core_mute = 1'b1;
      push_msg(2, "q");
      push_msg(3, "r");
      wait_fin(2, 3, "tmo_done2");
      check("tmo_abort_cnt", abort_cnt[2], 1);
      check("tmo_dig_unchanged", dig_data, 64'h6162);
      core_mute = 1'b0;
      wait_fin(3, 1, "tmo_done3");
      check("tmo_next_grant", first_cyc[3] > abort_cyc[2], 1);
      check("tmo_next_digest", dig_data, 64'h72);

      // stray digest_ready while idle
      step();
      core_inj = 1'b1;
      step();
      core_inj = 1'b0;
      repeat (4) step();
      check("stray_dig_data", dig_data, 64'h72);
      check("stray_no_valid", done_cnt[0] + done_cnt[1] + done_cnt[2] + done_cnt[3], 7);

      // owner stalls mid-message; requester 3 must not be granted meanwhile
      push_msg(1, "abcd");
      wait_rdy(1, 6, "stall_two_bytes");
      stall[1] = 1'b1;
      push_msg(3, "zz");
      repeat (20) step();
      check("stall_no_grant", ready_cnt[3], 2);
      check("stall_no_abort", abort_cnt[1], 0);
      stall[1] = 1'b0;
      wait_fin(1, 2, "stall_done1");
      wait_fin(3, 2, "stall_done3");
      check("stall_digest1", rdig[1], 64'h61626364);
      check("stall_digest3", rdig[3], 64'h7a7a);

      // reset in the middle of "abcdef", while the 4th byte is presented
      push_msg(0, "abcdef");
      wait_rdy(0, 13, "rst_three_bytes");
      b = 0;
      while (!req_ready[0] && b < 20) begin
         step();
         b++;
      end
      check("rst_in_send", req_ready[0], 1'b1);
      rst = 1'b1;
      #1;
      check_quiet("midrst");
      for (int i = 0; i < N; i++) begin
         src_wr[i] = 0; src_rd[i] = 0; pop_pend[i] = 1'b0;
      end
      repeat (2) step();
      rst = 1'b0;
      step();
      push_msg(0, "xy");
      wait_fin(0, 4, "post_rst_done");
      check("post_rst_digest", dig_data, 64'h7879);
      check("post_rst_rdig", rdig[0], 64'h7879);

      repeat (3) step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
